// File: rtl/vga_pkg.sv
// Shared 640x480 raster timing and RGB565 field layout, used by the scanner and
// by the sprite colour modules that feed it.
package vga_pkg;
   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_H_TOT  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;
   localparam int VGA_V_TOT  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // Top bit of each RGB565 field; the DAC takes the upper 4 bits of each.
   localparam int RGB_R_HI = 15;
   localparam int RGB_G_HI = 10;
   localparam int RGB_B_HI = 4;

   function automatic logic [11:0] rgb565_to_444(input logic [15:0] c);
      return {c[RGB_R_HI -: 4], c[RGB_G_HI -: 4], c[RGB_B_HI -: 4]};
   endfunction
endpackage

// File: rtl/vga_pix_div.sv
// Pixel-clock divider: pix_tick pulses once every DIV system clocks.
module vga_pix_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic pix_tick
);
   localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

   logic [3:0] r_div;
   logic       r_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div <= '0;
         r_en  <= 1'b0;
      end else begin
         r_en  <= 1'b1;
         r_div <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
      end
   end

   // r_en keeps the tick quiet in the cycle right after reset, which matters for DIV = 1.
   assign pix_tick = r_en & (r_div == DIV_LAST);
endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scanner: h/v position counters, syncs delayed one pixel, and
// registered RGB444 output sampled from the sprite colour bus.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int DIV    = 4,
   parameter int H_VIS  = VGA_H_VIS,
   parameter int H_FP   = VGA_H_FP,
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int V_VIS  = VGA_V_VIS,
   parameter int V_FP   = VGA_V_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] color,
   output logic [9:0]  col,
   output logic [8:0]  row,
   output logic        visible,
   output logic        pix_tick,
   output logic        frame_tick,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        hs,
   output logic        vs
);
   localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS_C = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C = 10'(V_VIS);
   localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

   logic        w_tick;
   logic        w_h_wrap;
   logic        w_v_wrap;
   logic        w_vis_nxt;
   logic        w_frame;
   logic [9:0]  w_h_nxt;
   logic [9:0]  w_v_nxt;
   logic [11:0] w_rgb;

   logic [9:0]  r_h;
   logic [9:0]  r_v;
   logic        r_first;
   logic [9:0]  r_col;
   logic [8:0]  r_row;
   logic        r_vis;
   logic [3:0]  r_r;
   logic [3:0]  r_g;
   logic [3:0]  r_b;
   logic        r_hs;
   logic        r_vs;

   vga_pix_div #(.DIV(DIV)) u_pix_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .pix_tick (w_tick)
   );

   // r_first makes the first tick after reset present (0,0) instead of stepping past it.
   always_comb begin
      w_h_wrap = (r_h == H_LAST);
      w_v_wrap = (r_v == V_LAST);
      w_h_nxt  = w_h_wrap ? 10'd0 : r_h + 10'd1;
      w_v_nxt  = r_v;
      if (w_h_wrap) begin
         w_v_nxt = w_v_wrap ? 10'd0 : r_v + 10'd1;
      end
      if (r_first) begin
         w_h_nxt = 10'd0;
         w_v_nxt = 10'd0;
      end
      w_vis_nxt = (w_h_nxt < H_VIS_C) && (w_v_nxt < V_VIS_C);
      w_frame   = w_tick && (r_first || (w_h_wrap && w_v_wrap));
   end

   assign w_rgb = rgb565_to_444(color);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_h     <= '0;
         r_v     <= '0;
         r_first <= 1'b1;
         r_col   <= '0;
         r_row   <= '0;
         r_vis   <= 1'b0;
         r_r     <= '0;
         r_g     <= '0;
         r_b     <= '0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
      end else if (w_tick) begin
         r_first <= 1'b0;
         r_h     <= w_h_nxt;
         r_v     <= w_v_nxt;
         r_vis   <= w_vis_nxt;
         r_col   <= w_vis_nxt ? w_h_nxt : 10'd0;
         r_row   <= w_vis_nxt ? w_v_nxt[8:0] : 9'd0;
         // Colour and syncs describe the pixel that was on the bus up to this tick.
         r_r     <= r_vis ? w_rgb[11:8] : 4'd0;
         r_g     <= r_vis ? w_rgb[7:4]  : 4'd0;
         r_b     <= r_vis ? w_rgb[3:0]  : 4'd0;
         r_hs    <= !((r_h >= HS_BEG) && (r_h <= HS_END));
         r_vs    <= !((r_v >= VS_BEG) && (r_v <= VS_END));
      end
   end

   assign col        = r_col;
   assign row        = r_row;
   assign visible    = r_vis;
   assign pix_tick   = w_tick;
   assign frame_tick = w_frame;
   assign r          = r_r;
   assign g          = r_g;
   assign b          = r_b;
   assign hs         = r_hs;
   assign vs         = r_vs;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a default-timing DIV=4 instance and a short-frame DIV=1
// instance, both checked against a raster model indexed by linear pixel position.
module tb_vga_scan_ctrl;
   localparam int A_DIV = 4;
   localparam int B_DIV = 1;
   localparam int B_VV  = 12;
   localparam int B_VF  = 2;
   localparam int B_VS  = 2;
   localparam int B_VB  = 3;

   localparam int P_DIV [2] = '{A_DIV, B_DIV};
   localparam int P_HV  [2] = '{640, 640};
   localparam int P_HF  [2] = '{16, 16};
   localparam int P_HS  [2] = '{96, 96};
   localparam int P_HB  [2] = '{48, 48};
   localparam int P_VV  [2] = '{480, B_VV};
   localparam int P_VF  [2] = '{10, B_VF};
   localparam int P_VS  [2] = '{2, B_VS};
   localparam int P_VB  [2] = '{33, B_VB};

   localparam logic [35:0] RESET_VEC = 36'h3;

   logic        clk;
   logic        rst_a_n, rst_b_n;
   logic [15:0] color_a, color_b;
   logic [9:0]  a_col, b_col;
   logic [8:0]  a_row, b_row;
   logic        a_visible, b_visible, a_pix_tick, b_pix_tick, a_frame_tick, b_frame_tick;
   logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
   logic        a_hs, a_vs, b_hs, b_vs;

   int n_cmp = 0;
   int n_bad = 0;

   int          m_e   [2];
   int          m_pos [2];
   logic [9:0]  x_col [2];
   logic [8:0]  x_row [2];
   logic        x_vis [2];
   logic [3:0]  x_r   [2];
   logic [3:0]  x_g   [2];
   logic [3:0]  x_b   [2];
   logic        x_hs  [2];
   logic        x_vs  [2];

   vga_scan_ctrl #(.DIV(A_DIV)) u_dut_a (
      .clk(clk), .rst_n(rst_a_n), .color(color_a), .col(a_col), .row(a_row),
      .visible(a_visible), .pix_tick(a_pix_tick), .frame_tick(a_frame_tick),
      .r(a_r), .g(a_g), .b(a_b), .hs(a_hs), .vs(a_vs)
   );

   vga_scan_ctrl #(.DIV(B_DIV), .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)) u_dut_b (
      .clk(clk), .rst_n(rst_b_n), .color(color_b), .col(b_col), .row(b_row),
      .visible(b_visible), .pix_tick(b_pix_tick), .frame_tick(b_frame_tick),
      .r(b_r), .g(b_g), .b(b_b), .hs(b_hs), .vs(b_vs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ht(input int d);
      return P_HV[d] + P_HF[d] + P_HS[d] + P_HB[d];
   endfunction

   function automatic int vt(input int d);
      return P_VV[d] + P_VF[d] + P_VS[d] + P_VB[d];
   endfunction

   function automatic bit m_tick(input int d);
      return (m_e[d] >= 1) && ((m_e[d] % P_DIV[d]) == P_DIV[d] - 1);
   endfunction

   function automatic int m_next(input int d);
      return (m_pos[d] < 0) ? 0 : (m_pos[d] + 1) % (ht(d) * vt(d));
   endfunction

   function automatic logic [35:0] m_exp(input int d);
      logic pt;
      pt = m_tick(d);
      return {x_col[d], x_row[d], x_vis[d], pt, pt & (m_next(d) == 0),
              x_r[d], x_g[d], x_b[d], x_hs[d], x_vs[d]};
   endfunction

   task automatic m_reset(input int d);
      m_e[d] = 0;  m_pos[d] = -1;
      x_col[d] = '0; x_row[d] = '0; x_vis[d] = 1'b0;
      x_r[d] = '0; x_g[d] = '0; x_b[d] = '0;
      x_hs[d] = 1'b1; x_vs[d] = 1'b1;
   endtask

   // Predicts the effect of the coming rising edge, given the colour on the bus.
   task automatic m_step(input int d, input logic [15:0] c);
      int o, n, oh, ov, nh, nv;
      bit o_vis, n_vis;
      if (m_tick(d)) begin
         o = m_pos[d];
         n = m_next(d);
         nh = n % ht(d);
         nv = n / ht(d);
         n_vis = (nh < P_HV[d]) && (nv < P_VV[d]);
         x_vis[d] = n_vis;
         x_col[d] = n_vis ? 10'(nh) : 10'd0;
         x_row[d] = n_vis ? 9'(nv) : 9'd0;
         oh = (o >= 0) ? o % ht(d) : 0;
         ov = (o >= 0) ? o / ht(d) : 0;
         o_vis = (o >= 0) && (oh < P_HV[d]) && (ov < P_VV[d]);
         x_r[d] = o_vis ? c[15:12] : 4'd0;
         x_g[d] = o_vis ? c[10:7]  : 4'd0;
         x_b[d] = o_vis ? c[4:1]   : 4'd0;
         x_hs[d] = !((o >= 0) && (oh >= P_HV[d] + P_HF[d]) && (oh < P_HV[d] + P_HF[d] + P_HS[d]));
         x_vs[d] = !((o >= 0) && (ov >= P_VV[d] + P_VF[d]) && (ov < P_VV[d] + P_VF[d] + P_VS[d]));
         m_pos[d] = n;
      end
      m_e[d]++;
   endtask

   task automatic do_reset(input int d);
      @(negedge clk);
      if (d == 0) begin rst_a_n = 1'b0; color_a = '0; end
      else        begin rst_b_n = 1'b0; color_b = '0; end
      repeat (3) @(negedge clk);
      if (d == 0) rst_a_n = 1'b1; else rst_b_n = 1'b1;
      m_reset(d);
   endtask

   task automatic test_reset();
      rst_a_n = 1'b0; rst_b_n = 1'b0; color_a = '0; color_b = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({a_col, a_row} !== 19'd0) begin n_bad++; $display("FAIL reset_a_colrow got=%h want=0", {a_col, a_row}); end
      n_cmp++; if ({a_visible, a_pix_tick, a_frame_tick} !== 3'b000) begin n_bad++; $display("FAIL reset_a_flags got=%b want=000", {a_visible, a_pix_tick, a_frame_tick}); end
      n_cmp++; if ({a_r, a_g, a_b} !== 12'h000) begin n_bad++; $display("FAIL reset_a_rgb got=%h want=000", {a_r, a_g, a_b}); end
      n_cmp++; if ({a_hs, a_vs} !== 2'b11) begin n_bad++; $display("FAIL reset_a_sync got=%b want=11", {a_hs, a_vs}); end
      n_cmp++; if ({b_col, b_row} !== 19'd0) begin n_bad++; $display("FAIL reset_b_colrow got=%h want=0", {b_col, b_row}); end
      n_cmp++; if ({b_visible, b_pix_tick, b_frame_tick} !== 3'b000) begin n_bad++; $display("FAIL reset_b_flags got=%b want=000", {b_visible, b_pix_tick, b_frame_tick}); end
      n_cmp++; if ({b_r, b_g, b_b} !== 12'h000) begin n_bad++; $display("FAIL reset_b_rgb got=%h want=000", {b_r, b_g, b_b}); end
      n_cmp++; if ({b_hs, b_vs} !== 2'b11) begin n_bad++; $display("FAIL reset_b_sync got=%b want=11", {b_hs, b_vs}); end
   endtask

   task automatic test_pix_tick();
      int last, nt;
      last = -1; nt = 0;
      do_reset(0);
      for (int k = 0; k < 40; k++) begin
         n_cmp++;
         if ({a_col, a_row, a_visible, a_pix_tick, a_frame_tick, a_r, a_g, a_b, a_hs, a_vs} !== m_exp(0)) begin
            n_bad++;
            $display("FAIL tick_a_outputs cyc=%0d got=%h want=%h", k,
                     {a_col, a_row, a_visible, a_pix_tick, a_frame_tick, a_r, a_g, a_b, a_hs, a_vs}, m_exp(0));
            break;
         end
         if (a_pix_tick) begin
            n_cmp++;
            if (last < 0) begin
               if (a_frame_tick !== 1'b1) begin n_bad++; $display("FAIL first_tick_frame got=%b want=1", a_frame_tick); end
            end else if (k - last != 4) begin
               n_bad++; $display("FAIL tick_spacing got=%0d want=4", k - last);
            end
            last = k;
            nt++;
         end
         color_a = 16'($urandom);
         m_step(0, color_a);
         @(negedge clk);
      end
      n_cmp++; if (nt != 10) begin n_bad++; $display("FAIL tick_count got=%0d want=10", nt); end
   endtask

   task automatic test_line();
      int tk, hs_first, hs_low;
      tk = -1; hs_first = -1; hs_low = 0;
      do_reset(0);
      for (int k = 0; k < 3400; k++) begin
         n_cmp++;
         if ({a_col, a_row, a_visible, a_pix_tick, a_frame_tick, a_r, a_g, a_b, a_hs, a_vs} !== m_exp(0)) begin
            n_bad++;
            $display("FAIL line_a_outputs cyc=%0d got=%h want=%h", k,
                     {a_col, a_row, a_visible, a_pix_tick, a_frame_tick, a_r, a_g, a_b, a_hs, a_vs}, m_exp(0));
            break;
         end
         if (a_hs === 1'b0) begin
            hs_low++;
            if (hs_first < 0) hs_first = tk;
         end
         if (a_pix_tick) begin
            if (a_frame_tick) tk = 0; else tk++;
         end
         color_a = 16'($urandom);
         m_step(0, color_a);
         @(negedge clk);
      end
      n_cmp++; if (hs_first != 657) begin n_bad++; $display("FAIL hs_start got=%0d want=657", hs_first); end
      n_cmp++; if (hs_low != 96 * A_DIV) begin n_bad++; $display("FAIL hs_width_clks got=%0d want=%0d", hs_low, 96 * A_DIV); end
   endtask

   task automatic test_color();
      bit chk0, chk700;
      logic [15:0] c;
      chk0 = 0; chk700 = 0;
      do_reset(0);
      for (int k = 0; k < 3400; k++) begin
         n_cmp++;
         if ({a_col, a_row, a_visible, a_pix_tick, a_frame_tick, a_r, a_g, a_b, a_hs, a_vs} !== m_exp(0)) begin
            n_bad++;
            $display("FAIL color_a_outputs cyc=%0d got=%h want=%h", k,
                     {a_col, a_row, a_visible, a_pix_tick, a_frame_tick, a_r, a_g, a_b, a_hs, a_vs}, m_exp(0));
            break;
         end
         if (chk0) begin
            n_cmp++;
            if ({a_r, a_g, a_b} !== 12'hf00) begin n_bad++; $display("FAIL red_at_origin got=%h want=f00", {a_r, a_g, a_b}); end
            chk0 = 0;
         end
         if (chk700) begin
            n_cmp++;
            if ({a_r, a_g, a_b} !== 12'h000) begin n_bad++; $display("FAIL white_offscreen got=%h want=000", {a_r, a_g, a_b}); end
            chk700 = 0;
         end
         if (m_pos[0] == 0) c = 16'hf800;
         else if (m_pos[0] >= 0 && (m_pos[0] % 800) == 700) c = 16'hffff;
         else c = 16'($urandom);
         if (m_tick(0) && m_pos[0] == 0) chk0 = 1;
         if (m_tick(0) && m_pos[0] >= 0 && (m_pos[0] % 800) == 700) chk700 = 1;
         color_a = c;
         m_step(0, c);
         @(negedge clk);
      end
   endtask

   task automatic test_mid_reset();
      bit reached, got, chk_next;
      reached = 0; got = 0; chk_next = 0;
      do_reset(1);
      for (int k = 0; k < 10000; k++) begin
         if (m_pos[1] == 5 * 800 + 300) begin reached = 1; break; end
         n_cmp++;
         if ({b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs} !== m_exp(1)) begin
            n_bad++;
            $display("FAIL pre_reset_b cyc=%0d got=%h want=%h", k,
                     {b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs}, m_exp(1));
            break;
         end
         color_b = 16'($urandom);
         m_step(1, color_b);
         @(negedge clk);
      end
      n_cmp++; if (!reached) begin n_bad++; $display("FAIL mid_reset_reach got=0 want=1"); end
      rst_b_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs} !== RESET_VEC) begin
            n_bad++;
            $display("FAIL mid_reset_vals cyc=%0d got=%h want=%h", k,
                     {b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs}, RESET_VEC);
         end
      end
      rst_b_n = 1'b1;
      m_reset(1);
      for (int k = 0; k < 20; k++) begin
         n_cmp++;
         if ({b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs} !== m_exp(1)) begin
            n_bad++;
            $display("FAIL restart_b cyc=%0d got=%h want=%h", k,
                     {b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs}, m_exp(1));
            break;
         end
         if (chk_next) begin
            n_cmp++;
            if ({b_col, b_row, b_visible} !== {10'd0, 9'd0, 1'b1}) begin
               n_bad++; $display("FAIL restart_origin got=%h want=%h", {b_col, b_row, b_visible}, {10'd0, 9'd0, 1'b1});
            end
            chk_next = 0;
         end
         if (b_pix_tick && !got) begin
            n_cmp++;
            if (b_frame_tick !== 1'b1) begin n_bad++; $display("FAIL restart_frame_tick got=%b want=1", b_frame_tick); end
            got = 1;
            chk_next = 1;
         end
         color_b = 16'($urandom);
         m_step(1, color_b);
         @(negedge clk);
      end
   endtask

   task automatic test_frame();
      int nt, nft, tk, vs_first, vs_low;
      nt = 0; nft = 0; tk = -1; vs_first = -1; vs_low = 0;
      do_reset(1);
      for (int k = 0; k < 15400; k++) begin
         n_cmp++;
         if ({b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs} !== m_exp(1)) begin
            n_bad++;
            $display("FAIL frame_b_outputs cyc=%0d got=%h want=%h", k,
                     {b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs}, m_exp(1));
            break;
         end
         if (b_vs === 1'b0) begin
            vs_low++;
            if (vs_first < 0) vs_first = tk;
         end
         if (b_pix_tick) begin
            if (b_frame_tick) begin
               if (nft > 0) begin
                  n_cmp++;
                  if (nt != 800 * 19) begin n_bad++; $display("FAIL frame_length got=%0d want=%0d", nt, 800 * 19); end
               end
               nft++;
               nt = 0;
               tk = 0;
            end else begin
               tk++;
            end
            nt++;
         end
         color_b = 16'($urandom);
         m_step(1, color_b);
         @(negedge clk);
      end
      n_cmp++; if (nft != 2) begin n_bad++; $display("FAIL frame_tick_count got=%0d want=2", nft); end
      n_cmp++; if (vs_first != 14 * 800 + 1) begin n_bad++; $display("FAIL vs_start got=%0d want=%0d", vs_first, 14 * 800 + 1); end
      n_cmp++; if (vs_low != 2 * 800) begin n_bad++; $display("FAIL vs_width_clks got=%0d want=%0d", vs_low, 2 * 800); end
   endtask

   task automatic test_div1();
      logic [9:0] p_col;
      logic       p_vis;
      int         last_row;
      int         n_end;
      p_col = '0; p_vis = 1'b0; last_row = -1; n_end = 0;
      do_reset(1);
      for (int k = 0; k < 1800; k++) begin
         n_cmp++;
         if ({b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs} !== m_exp(1)) begin
            n_bad++;
            $display("FAIL div1_outputs cyc=%0d got=%h want=%h", k,
                     {b_col, b_row, b_visible, b_pix_tick, b_frame_tick, b_r, b_g, b_b, b_hs, b_vs}, m_exp(1));
            break;
         end
         if (p_vis && p_col != 10'd639) begin
            n_cmp++;
            if (b_col !== p_col + 10'd1) begin n_bad++; $display("FAIL div1_col_step got=%0d want=%0d", b_col, p_col + 10'd1); break; end
         end
         if (p_vis && p_col == 10'd639) begin
            n_cmp++;
            n_end++;
            if (b_visible !== 1'b0) begin n_bad++; $display("FAIL div1_after_639 got=%b want=0", b_visible); break; end
         end
         if (b_visible && b_col == 10'd0) begin
            if (last_row >= 0) begin
               n_cmp++;
               if (int'(b_row) != last_row + 1) begin n_bad++; $display("FAIL div1_row_step got=%0d want=%0d", b_row, last_row + 1); break; end
            end
            last_row = int'(b_row);
         end
         p_col = b_col;
         p_vis = b_visible;
         color_b = 16'($urandom);
         m_step(1, color_b);
         @(negedge clk);
      end
      n_cmp++; if (n_end != 2) begin n_bad++; $display("FAIL div1_line_ends got=%0d want=2", n_end); end
   endtask

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0; color_a = '0; color_b = '0;
      m_reset(0);
      m_reset(1);
      test_reset();
      test_pix_tick();
      test_line();
      test_color();
      test_mid_reset();
      test_frame();
      test_div1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
